hc_gate_tester: RTL

Synchronous self-checking tester for quad 2-input 74HC-family gate models (74HC32 OR, 74HC08 AND, 74HC00 NAND, 74HC86 XOR). On `start` it drives all four truth-table vectors onto all four gate channels and waits a programmable settle time after each vector. It then compares the four channel outputs against a reference function and reports a per-channel fail mask and pass/fail status. It is the response-checking end of the gate stimulus path and replaces hand-written monitor benches for on-board or in-sim gate checks.

---
 rtl/hc_gate_tester_pkg.sv | 30 +++
 rtl/hc_gate_tester_model.sv | 24 ++
 rtl/hc_gate_tester.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/hc_gate_tester_pkg.sv
// Shared encodings for the 74HC quad-gate tester: gate functions, FSM states
// and the truth-table vector order used to exercise every channel.
package hc_gate_tester_pkg;

  // Gate function selected by gate_type.
  typedef enum logic [1:0] {
    GATE_OR   = 2'd0,
    GATE_AND  = 2'd1,
    GATE_NAND = 2'd2,
    GATE_XOR  = 2'd3
  } gate_e;

  // Tester FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2
  } state_e;

  // Vector order as (a,b): (0,0), (1,0), (1,1), (0,1); bit k holds vector k.
  localparam logic [3:0] VEC_A    = 4'b0110;
  localparam logic [3:0] VEC_B    = 4'b1100;
  localparam logic [1:0] LAST_VEC = 2'd3;

  // Returns {a,b} for vector index idx.
  function automatic logic [1:0] vec_ab(input logic [1:0] idx);
    return {VEC_A[idx], VEC_B[idx]};
  endfunction

endpackage

// File: rtl/hc_gate_tester_model.sv
// Combinational reference for one 2-input 74HC gate channel. Shared with
// other gate benches, so it carries no clock or state.
module hc_gate_model
  import hc_gate_tester_pkg::*;
(
  input  logic [1:0] gate_type,
  input  logic       a,
  input  logic       b,
  output logic       y
);

  // Expected output of the selected gate function.
  always_comb begin
    y = 1'b0;
    case (gate_type)
      GATE_OR:   y = a | b;
      GATE_AND:  y = a & b;
      GATE_NAND: y = ~(a & b);
      GATE_XOR:  y = a ^ b;
      default:   y = 1'b0;
    endcase
  end

endmodule

// File: rtl/hc_gate_tester.sv
// Self-checking tester for a quad 2-input gate. On start it walks the four
// truth-table vectors onto all channels, waits SETTLE_CYCLES after each load,
// compares dut_y against the reference and reports pass / fail_mask / fail_vec.
module hc_gate_tester
  import hc_gate_tester_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] gate_type,
  input  logic [3:0] dut_y,
  output logic [3:0] dut_a,
  output logic [3:0] dut_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask,
  output logic [1:0] fail_vec
);

  // Settle counter reaches this value on the last settle edge of a vector.
  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [1:0] gate_q, gate_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] mask_q, mask_d;
  logic [1:0] vec_q, vec_d;
  logic       first_fail_q, first_fail_d;
  logic       exp_y;
  logic [3:0] mismatch;

  // Reference output for the vector currently on the bus, using the latched gate.
  hc_gate_model u_model (
    .gate_type (gate_q),
    .a         (a_q),
    .b         (b_q),
    .y         (exp_y)
  );

  assign mismatch = dut_y ^ {4{exp_y}};

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_SETTLE;
      ST_SETTLE: if (cnt_q == CNT_LAST) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = (idx_q == LAST_VEC) ? ST_IDLE : ST_SETTLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath / result next values; start while busy never reaches the IDLE branch.
  always_comb begin
    gate_d       = gate_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_d       = pass_q;
    mask_d       = mask_q;
    vec_d        = vec_q;
    first_fail_d = first_fail_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          gate_d       = gate_type;
          idx_d        = 2'd0;
          {a_d, b_d}   = vec_ab(2'd0);
          cnt_d        = 8'd0;
          pass_d       = 1'b0;
          mask_d       = 4'd0;
          vec_d        = 2'd0;
          first_fail_d = 1'b0;
          busy_d       = 1'b1;
        end
      end
      ST_SETTLE: cnt_d = cnt_q + 8'd1;
      ST_SAMPLE: begin
        mask_d = mask_q | mismatch;
        if ((mismatch != 4'd0) && !first_fail_q) begin
          vec_d        = idx_q;
          first_fail_d = 1'b1;
        end
        if (idx_q != LAST_VEC) begin
          idx_d      = idx_q + 2'd1;
          {a_d, b_d} = vec_ab(idx_q + 2'd1);
          cnt_d      = 8'd0;
        end else begin
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = ((mask_q | mismatch) == 4'd0);
        end
      end
      default: ;
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_q       <= 2'd0;
      idx_q        <= 2'd0;
      cnt_q        <= 8'd0;
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      mask_q       <= 4'd0;
      vec_q        <= 2'd0;
      first_fail_q <= 1'b0;
    end else begin
      gate_q       <= gate_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      mask_q       <= mask_d;
      vec_q        <= vec_d;
      first_fail_q <= first_fail_d;
    end
  end

  assign dut_a     = {4{a_q}};
  assign dut_b     = {4{b_q}};
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = mask_q;
  assign fail_vec  = vec_q;

endmodule
